if_fetch_stage: RTL and testbench

//  Instruction-fetch stage with integrated IF/ID pipeline register. Sits between
//  the PC register and the decode stage. Drives PC_i to instruction memory and

---
 rtl/if_fetch_stage.sv | 178 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
//   Instruction-fetch stage with the IF/ID pipeline register folded in.
//   Presents PC_i to instruction memory, waits on a valid/ready handshake,
//   and loads the fetched word plus PC+4 into IF/ID. A one-entry buffer
//   catches a word that arrives while decode is stalled, so the PC can
//   advance without losing it. PC_Keep tells the PC register to hold.
//
// Ports
//   clk, reset         clock (rising edge), async active-low reset
//   PC_i               current PC; driven straight out as imem_addr
//   imem_req/addr      fetch request and address
//   imem_ready/rdata   memory response (rdata valid when ready=1)
//   ID_Stall           hazard unit: hold IF/ID
//   IF_Flush           taken branch/jump: kill IF, redirect PC
//   PC_Keep            1 = PC register holds (combinational)
//   IFID_Instr/PC4     registered instruction and its PC+4
//   IFID_Valid         1 = IFID_Instr is a real instruction
//   fetch_err          sticky fetch timeout flag
//
// Build option
//   FETCH_TIMEOUT_EN   adds an 8-bit wait counter; a fetch that stays
//                      unanswered for MAX_WAIT cycles is completed as a
//                      bubble and fetch_err is set. Undefined: waits forever,
//                      fetch_err tied to 0.

module if_fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        ID_Stall,
    input  logic        IF_Flush,
    output logic        PC_Keep,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PC4,
    output logic        IFID_Valid,
    output logic        fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..255");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    // Buffer occupancy is implied by S_HOLD, so no separate valid flag.
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] pc_plus4;
    logic        timeout;

    assign pc_plus4  = PC_i + 32'd4;   // wraps modulo 2^32
    assign imem_addr = PC_i;           // stable while waiting since PC_Keep=1

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;

    // Flush outranks a timeout landing in the same cycle.
    assign timeout = (state_q == S_REQ) && !imem_ready && !IF_Flush &&
                     (wait_q == MAX_WAIT_C);

    always_comb begin
        wait_d = wait_q + 8'd1;
        if (state_q != S_REQ || imem_ready || IF_Flush || timeout)
            wait_d = 8'd0;
        err_d = err_q | timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        imem_req    = 1'b0;
        PC_Keep     = 1'b1;
        case (state_q)
            S_IDLE: state_d = S_REQ;   // flush ignored here
            S_REQ: begin
                imem_req = 1'b1;
                if (IF_Flush) begin
                    // rdata this cycle is dropped; PC loads the redirect target
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    PC_Keep = 1'b0;
                end else if (imem_ready) begin
                    PC_Keep = 1'b0;
                    if (ID_Stall) begin
                        // decode busy: park the word so the PC can move on
                        buf_instr_d = imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = S_HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    PC_Keep = 1'b0;
                end else if (!ID_Stall) begin
                    instr_d = NOP_INSTR;   // bubble while memory is slow
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (IF_Flush) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    PC_Keep = 1'b0;
                    state_d = S_REQ;
                end else if (!ID_Stall) begin
                    instr_d = buf_instr_q;
                    pc4_d   = buf_pc4_q;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            instr_q     <= NOP_INSTR;
            pc4_q       <= 32'd0;
            valid_q     <= 1'b0;
            buf_instr_q <= 32'd0;
            buf_pc4_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
        end
    end

    assign IFID_Instr = instr_q;
    assign IFID_PC4   = pc4_q;
    assign IFID_Valid = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
//   Directed scenarios followed by random ready/stall/flush traffic, all
//   compared against a queue-based reference model of the fetch rules.
//   The bench plays the PC register: PC follows the model's expected keep.

module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int TB_MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        ID_Stall;
    logic        IF_Flush;
    logic        PC_Keep;
    logic [31:0] IFID_Instr;
    logic [31:0] IFID_PC4;
    logic        IFID_Valid;
    logic        fetch_err;

    always #5 clk = ~clk;

    if_fetch_stage #(.NOP_INSTR(NOP), .MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .PC_i(PC_i),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ID_Stall(ID_Stall), .IF_Flush(IF_Flush), .PC_Keep(PC_Keep),
        .IFID_Instr(IFID_Instr), .IFID_PC4(IFID_PC4),
        .IFID_Valid(IFID_Valid), .fetch_err(fetch_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    // reference model: an idle flag, a pending-word queue, IF/ID contents
    logic        m_idle;
    logic [63:0] m_buf[$];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid, m_err;
    int          m_wait;
    logic        pc_upd;
    logic [31:0] pc_nxt;

    task automatic model_reset();
        m_idle = 1'b1; m_buf.delete();
        m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0; m_err = 1'b0;
        m_wait = 0; pc_upd = 1'b0; pc_nxt = 32'd0;
    endtask

    // assert reset off-edge, check the async values, release mid-high phase
    task automatic do_reset();
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_keep", {31'd0, PC_Keep}, 32'd1);
        chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
        chk("rst_instr", IFID_Instr, NOP);
        chk("rst_pc4", IFID_PC4, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        PC_i = 32'd0; imem_ready = 1'b0; ID_Stall = 1'b0; IF_Flush = 1'b0;
        imem_rdata = 32'd0;
        @(posedge clk); #2 reset = 1'b1;
    endtask

    task automatic cyc(input logic rdy, input logic stl, input logic fls,
                       input logic [31:0] rd, input logic [31:0] tgt);
        logic exp_keep, exp_req, tmo;
        @(negedge clk);
        if (pc_upd) PC_i = pc_nxt;
        imem_ready = rdy; ID_Stall = stl; IF_Flush = fls; imem_rdata = rd;
        #1;
        exp_req = !m_idle && m_buf.size() == 0;
        tmo = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo = exp_req && !fls && !rdy && m_wait == TB_MAX_WAIT;
`endif
        if (m_idle)                exp_keep = 1'b1;
        else if (fls)              exp_keep = 1'b0;
        else if (m_buf.size() != 0) exp_keep = 1'b1;
        else                       exp_keep = !(rdy || tmo);
        chk("req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("keep", {31'd0, PC_Keep}, {31'd0, exp_keep});
        chk("addr", imem_addr, PC_i);
        @(posedge clk); #1;
        pc_upd = !exp_keep;
        pc_nxt = fls ? tgt : PC_i + 32'd4;
        m_wait = (exp_req && !rdy && !fls && !tmo) ? m_wait + 1 : 0;
        if (m_idle) m_idle = 1'b0;
        else if (fls) begin
            m_instr = NOP; m_valid = 1'b0; m_buf.delete();
        end else if (m_buf.size() != 0) begin
            if (!stl) begin
                {m_instr, m_pc4} = m_buf.pop_front();
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            if (stl) m_buf.push_back({rd, PC_i + 32'd4});
            else begin
                m_instr = rd; m_pc4 = PC_i + 32'd4; m_valid = 1'b1;
            end
        end else if (tmo) begin
            m_instr = NOP; m_valid = 1'b0; m_err = 1'b1;
        end else if (!stl) begin
            m_instr = NOP; m_valid = 1'b0;
        end
        chk("instr", IFID_Instr, m_instr);
        chk("pc4", IFID_PC4, m_pc4);
        chk("valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
        chk("err", {31'd0, fetch_err}, {31'd0, m_err});
    endtask

    initial begin
        reset = 1'b1; PC_i = 32'd0; imem_ready = 1'b0; ID_Stall = 1'b0;
        IF_Flush = 1'b0; imem_rdata = 32'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // zero-wait stream 0,4,8 -> A,B,C
        cyc(1, 0, 0, 32'hAAAA_0001, 0);          // idle cycle
        cyc(1, 0, 0, 32'hAAAA_0001, 0);
        chk("t1_a", IFID_Instr, 32'hAAAA_0001);
        cyc(1, 0, 0, 32'hBBBB_0002, 0);
        cyc(1, 0, 0, 32'hCCCC_0003, 0);
        chk("t1_c", IFID_Instr, 32'hCCCC_0003);
        chk("t1_pc4", IFID_PC4, 32'h0000_000C);

        // redirect to 0x10, two wait cycles, then D
        cyc(0, 0, 1, 0, 32'h10);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_bubble", {31'd0, IFID_Valid}, 32'd0);
        cyc(1, 0, 0, 32'hDDDD_0004, 0);
        chk("t2_d", IFID_Instr, 32'hDDDD_0004);
        chk("t2_pc4", IFID_PC4, 32'h14);

        // ready under stall at 0x20, hold 3 cycles, release
        cyc(0, 0, 1, 0, 32'h20);
        cyc(1, 1, 0, 32'hEEEE_0005, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_e", IFID_Instr, 32'hEEEE_0005);
        chk("t3_pc4", IFID_PC4, 32'h24);

        // flush + stall + ready together
        cyc(1, 1, 1, 32'h1234_5678, 32'h40);
        chk("t4_nop", IFID_Instr, NOP);
        cyc(1, 0, 0, 32'h0BAD_F00D, 0);

        // PC+4 wrap
        cyc(0, 0, 1, 0, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 32'h7777_0007, 0);
        chk("wrap_pc4", IFID_PC4, 32'h0);

        // async reset while holding a buffered word
        cyc(1, 1, 0, 32'h5555_0008, 0);
        cyc(0, 1, 0, 0, 0);
        do_reset();
        cyc(1, 0, 0, 32'h6666_0009, 0);
        cyc(1, 0, 0, 32'h6666_0009, 0);

`ifdef FETCH_TIMEOUT_EN
        do_reset();
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < TB_MAX_WAIT + 1; i++) cyc(0, 0, 0, 0, 0);
        chk("t6_err", {31'd0, fetch_err}, 32'd1);
        cyc(1, 0, 0, 32'h1111_000A, 0);
        chk("t6_sticky", {31'd0, fetch_err}, 32'd1);
`endif

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 60, $urandom_range(99) < 25,
                $urandom_range(99) < 8, $urandom, $urandom & 32'hFFFF_FFFC);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
